// File: rtl/fp_mm_pkg.sv
// Shared types, constants and IEEE-754 single-precision arithmetic helpers for the
// matrix MAC engine. Denormals flush to zero; rounding is round-to-nearest-even.
package fp_mm_pkg;

  localparam int          FP_W    = 32;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_MUL  = 2'd1,
    L_ADD  = 2'd2
  } lane_state_t;

  // LSB position of flat element idx in an MSB-first packed vector of total bits
  function automatic int elem_lsb(input int total, input int w, input int idx);
    return total - w * (idx + 1);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [47:0]        p;
    logic [23:0]        m;
    logic               g;
    logic               st;
    logic signed [9:0]  e;
    logic [24:0]        mr;
    logic [31:0]        res;
    s = a[31] ^ b[31];
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0)) begin
      res = FP_QNAN;
    end else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      res = (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? FP_QNAN : {s, 8'hFF, 23'd0};
    end else if (a[30:23] == 8'h00 || b[30:23] == 8'h00) begin
      res = {s, 31'd0};
    end else if (e >= 10'sd255) begin
      res = {s, 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      res = {s, 31'd0};
    end else begin
      res = {s, e[7:0], mr[22:0]};
    end
    return res;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x;
    logic [31:0]       y;
    logic [7:0]        d;
    logic [26:0]       mx;
    logic [26:0]       my;
    logic [27:0]       sum;
    logic signed [9:0] e;
    logic [24:0]       mr;
    logic [31:0]       res;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // Alignment keeps guard/round bits and ORs everything shifted out into sticky
    if (d > 8'd26) begin
      my = 27'd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (i < int'(d)) my = {1'b0, my[26:2], my[1] | my[0]};
      end
    end
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, my};
    else                sum = {1'b0, mx} - {1'b0, my};
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!sum[26] && sum != 28'd0) begin
          sum = sum << 1;
          e   = e - 10'sd1;
        end
      end
    end
    mr = {1'b0, sum[26:3]} + {24'd0, sum[2] & (sum[1] | sum[0] | sum[3])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] != 23'd0) res = FP_QNAN;
      else if (y[30:23] == 8'hFF && x[31] != y[31]) res = FP_QNAN;
      else res = x;
    end else if (y[30:23] == 8'h00) begin
      res = (x[30:23] == 8'h00) ? {x[31] & y[31], 31'd0} : x;
    end else if (sum == 28'd0) begin
      res = FP_ZERO;
    end else if (e >= 10'sd255) begin
      res = {x[31], 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      res = {x[31], 31'd0};
    end else begin
      res = {x[31], e[7:0], mr[22:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_mac_lane.sv
// One multiply-accumulate lane: result = acc_in + a*b, a registered multiply stage
// followed by a registered add stage; done pulses the cycle after the add completes.
module fp_mac_lane
  import fp_mm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_acc_in,
  output logic        o_done,
  output logic [31:0] o_result
);

  lane_state_t r_state;
  lane_state_t w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc;
  logic [31:0] r_prod;
  logic [31:0] r_result;
  logic        r_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      L_IDLE:  if (i_start) w_next = L_MUL; else w_next = L_IDLE;
      L_MUL:   w_next = L_ADD;
      L_ADD:   w_next = L_IDLE;
      default: w_next = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= L_IDLE;
      r_a      <= FP_ZERO;
      r_b      <= FP_ZERO;
      r_acc    <= FP_ZERO;
      r_prod   <= FP_ZERO;
      r_result <= FP_ZERO;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == L_ADD);
      case (r_state)
        L_IDLE: begin
          if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= i_acc_in;
          end
        end
        L_MUL:   r_prod   <= fp_mul(r_a, r_b);
        L_ADD:   r_result <= fp_add(r_acc, r_prod);
        default: ;
      endcase
    end
  end

  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: rtl/fp_matrix_mac_engine.sv
// Single-precision matrix engine: C = A*B (+ D), output elements computed LANES at a
// time with strictly sequential k-order accumulation per element.
module fp_matrix_mac_engine
  import fp_mm_pkg::*;
#(
  parameter int M     = 2,
  parameter int K     = 2,
  parameter int N     = 2,
  parameter int LANES = 2,
  parameter int W     = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_mode,
  input  logic [W*M*K-1:0] in_a,
  input  logic [W*K*N-1:0] in_b,
  input  logic [W*M*N-1:0] in_d,
  output logic [W*M*N-1:0] out,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             busy
);

  localparam int NE = M * N;
  localparam int G  = (NE + LANES - 1) / LANES;
  localparam int GW = ($clog2(G + 1) > 1) ? $clog2(G + 1) : 1;
  localparam int KW = ($clog2(K + 1) > 1) ? $clog2(K + 1) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [W*M*K-1:0]   r_a;
  logic [W*K*N-1:0]   r_b;
  logic [W*M*N-1:0]   r_d;
  logic               r_acc_mode;
  logic [GW-1:0]      r_g;
  logic [KW-1:0]      r_k;
  logic [W-1:0]       r_acc [LANES];
  logic [LANES-1:0]   r_done_seen;
  logic [W*M*N-1:0]   r_out;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_in_ready;

  int                 w_e [LANES];
  logic [W-1:0]       w_lane_a [LANES];
  logic [W-1:0]       w_lane_b [LANES];
  logic [W-1:0]       w_lane_d [LANES];
  logic [W-1:0]       w_lane_res [LANES];
  logic [LANES-1:0]   w_active;
  logic [LANES-1:0]   w_start;
  logic [LANES-1:0]   w_lane_done;
  logic               w_all_done;
  logic               w_last_k;
  logic               w_last_g;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_e[l]      = int'(r_g) * LANES + l;
      w_active[l] = (w_e[l] < NE);
      w_start[l]  = (r_state == ISSUE) && w_active[l];
      w_lane_a[l] = FP_ZERO;
      w_lane_b[l] = FP_ZERO;
      w_lane_d[l] = FP_ZERO;
      if (w_active[l]) begin
        w_lane_a[l] = r_a[elem_lsb(W*M*K, W, (w_e[l] / N) * K + int'(r_k)) +: W];
        w_lane_b[l] = r_b[elem_lsb(W*K*N, W, int'(r_k) * N + (w_e[l] % N)) +: W];
        w_lane_d[l] = r_d[elem_lsb(W*NE, W, w_e[l]) +: W];
      end else begin
        w_lane_a[l] = FP_ZERO;
        w_lane_b[l] = FP_ZERO;
        w_lane_d[l] = FP_ZERO;
      end
    end
  end

  // Lanes may finish on different cycles, so done pulses are latched until all report
  assign w_all_done = &(r_done_seen | w_lane_done | ~w_active);
  assign w_last_k   = (r_k == KW'(K - 1));
  assign w_last_g   = (r_g == GW'(G - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = INIT; else w_next = IDLE;
      INIT:    w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_all_done) w_next = STORE; else w_next = WAIT;
      STORE: begin
        if (!w_last_k)      w_next = ISSUE;
        else if (w_last_g)  w_next = DONE;
        else                w_next = INIT;
      end
      DONE:    if (out_ack) w_next = IDLE; else w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fp_mac_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_start[l]),
      .i_a      (w_lane_a[l]),
      .i_b      (w_lane_b[l]),
      .i_acc_in (r_acc[l]),
      .o_done   (w_lane_done[l]),
      .o_result (w_lane_res[l])
    );
  end

  // Status outputs are registered from the next state so they align with r_state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next inside {INIT, ISSUE, WAIT, STORE});
      r_out_valid <= (w_next == DONE);
      r_in_ready  <= (w_next == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_acc_mode  <= 1'b0;
      r_g         <= '0;
      r_k         <= '0;
      r_done_seen <= '0;
      r_out       <= '0;
      for (int l = 0; l < LANES; l++) r_acc[l] <= FP_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_d        <= in_d;
            r_acc_mode <= acc_mode;
            r_g        <= '0;
          end
        end
        INIT: begin
          r_k <= '0;
          for (int l = 0; l < LANES; l++) begin
            if (w_active[l]) r_acc[l] <= r_acc_mode ? w_lane_d[l] : FP_ZERO;
          end
        end
        ISSUE: r_done_seen <= '0;
        WAIT:  r_done_seen <= r_done_seen | w_lane_done;
        STORE: begin
          for (int l = 0; l < LANES; l++) begin
            if (w_active[l]) r_acc[l] <= w_lane_res[l];
          end
          if (!w_last_k) begin
            r_k <= r_k + KW'(1);
          end else begin
            for (int l = 0; l < LANES; l++) begin
              if (w_active[l]) r_out[elem_lsb(W*NE, W, w_e[l]) +: W] <= w_lane_res[l];
            end
            if (!w_last_g) r_g <= r_g + GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign in_ready  = r_in_ready;

endmodule

// File: tb/tb_fp_matrix_mac_engine.sv
// Directed self-checking bench for fp_matrix_mac_engine: three configurations
// (2x2x2/2 lanes, 2x2x2/3 lanes, 1x3x2/1 lane) sharing one clock and reset.
module tb_fp_matrix_mac_engine;

  localparam logic [31:0] FZ = 32'h0000_0000;
  localparam logic [31:0] F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;
  localparam logic [31:0] FH = 32'h3F00_0000;

  localparam logic [127:0] IDENT    = {F1, FZ, FZ, F1};
  localparam logic [127:0] BMAT     = {F1, F2, F3, F4};
  localparam logic [127:0] DHALF    = {FH, FH, FH, FH};
  localparam logic [127:0] ACC_EXP  = {32'h3FC0_0000, 32'h4020_0000, 32'h4060_0000, 32'h4090_0000};
  localparam logic [127:0] PART_EXP = {32'h40E0_0000, 32'h4120_0000, 32'h4170_0000, 32'h41B0_0000};
  localparam logic [127:0] PART_G0  = {32'h40E0_0000, 32'h4120_0000, 32'h4170_0000, FZ};
  localparam logic [95:0]  NS_A     = {F1, F2, F3};
  localparam logic [191:0] NS_B     = {F1, FZ, FZ, F1, F1, F1};
  localparam logic [63:0]  NS_EXP   = {32'h4080_0000, 32'h40A0_0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic v0, rdy0, am0, val0, ack0, busy0;
  logic [127:0] a0, b0, d0, out0;
  logic v3, rdy3, am3, val3, ack3, busy3;
  logic [127:0] a3, b3, d3, out3;
  logic vn, rdyn, amn, valn, ackn, busyn;
  logic [95:0]  an;
  logic [191:0] bn;
  logic [63:0]  dn, outn;

  int n_checks = 0;
  int n_fail   = 0;

  fp_matrix_mac_engine #(.M(2), .K(2), .N(2), .LANES(2), .W(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .acc_mode(am0),
    .in_a(a0), .in_b(b0), .in_d(d0), .out(out0), .out_valid(val0),
    .out_ack(ack0), .busy(busy0));

  fp_matrix_mac_engine #(.M(2), .K(2), .N(2), .LANES(3), .W(32)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .acc_mode(am3),
    .in_a(a3), .in_b(b3), .in_d(d3), .out(out3), .out_valid(val3),
    .out_ack(ack3), .busy(busy3));

  fp_matrix_mac_engine #(.M(1), .K(3), .N(2), .LANES(1), .W(32)) u_dut_ns (
    .clk(clk), .rst(rst), .in_valid(vn), .in_ready(rdyn), .acc_mode(amn),
    .in_a(an), .in_b(bn), .in_d(dn), .out(outn), .out_valid(valn),
    .out_ack(ackn), .busy(busyn));

  // Waits for out_valid on the 2-lane instance; cyc = -1 on timeout
  task automatic wait_valid0(output int cyc, output int rises);
    logic prev;
    prev  = val0;
    rises = 0;
    cyc   = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (val0 && !prev) rises++;
      prev = val0;
      if (val0) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v0 = 1'b0; am0 = 1'b0; ack0 = 1'b0; a0 = '0; b0 = '0; d0 = '0;
    v3 = 1'b0; am3 = 1'b0; ack3 = 1'b0; a3 = '0; b3 = '0; d3 = '0;
    vn = 1'b0; amn = 1'b0; ackn = 1'b0; an = '0; bn = '0; dn = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (out0 !== 128'd0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out0); end
    n_checks++;
    if (val0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", val0); end
    n_checks++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_checks++;
    if (rdy0 !== 1'b1 || rdy3 !== 1'b1 || rdyn !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b%b%b want 111", rdy0, rdy3, rdyn);
    end
    n_checks++;
    if (out3 !== 128'd0 || outn !== 64'd0) begin
      n_fail++; $display("FAIL reset_out_others: got %h / %h want 0", out3, outn);
    end
  endtask

  task automatic test_identity(input string tag);
    int cyc, rises;
    @(negedge clk);
    a0 = IDENT; b0 = BMAT; d0 = DHALF; am0 = 1'b0; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    n_checks++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL %s_busy_start: got %b want 1", tag, busy0); end
    wait_valid0(cyc, rises);
    n_checks++;
    if (cyc < 0) begin n_fail++; $display("FAIL %s_timeout: out_valid never rose (want within 500 cycles)", tag); end
    n_checks++;
    if (out0 !== BMAT) begin n_fail++; $display("FAIL %s_out: got %h want %h", tag, out0, BMAT); end
    n_checks++;
    if (busy0 !== 1'b0 || rdy0 !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_flags: busy=%b in_ready=%b want 0 0", tag, busy0, rdy0);
    end
    n_checks++;
    if (rises !== 1) begin n_fail++; $display("FAIL %s_valid_rises: got %0d want 1", tag, rises); end
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    n_checks++;
    if (val0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_fail++; $display("FAIL %s_ack: out_valid=%b in_ready=%b want 0 1", tag, val0, rdy0);
    end
  endtask

  task automatic test_accumulate();
    int cyc, rises;
    @(negedge clk);
    a0 = IDENT; b0 = BMAT; d0 = DHALF; am0 = 1'b1; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0; am0 = 1'b0;
    wait_valid0(cyc, rises);
    n_checks++;
    if (cyc < 0) begin n_fail++; $display("FAIL accum_timeout: out_valid never rose (want within 500 cycles)"); end
    n_checks++;
    if (out0 !== ACC_EXP) begin n_fail++; $display("FAIL accum_out: got %h want %h", out0, ACC_EXP); end
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    n_checks++;
    if (val0 !== 1'b0) begin n_fail++; $display("FAIL accum_ack: out_valid=%b want 0", val0); end
  endtask

  task automatic test_partial_group();
    logic [127:0] prev, snap;
    int changes;
    bit seen;
    changes = 0; seen = 1'b0; snap = '0;
    @(negedge clk);
    a3 = BMAT; b3 = BMAT; d3 = DHALF; am3 = 1'b0; v3 = 1'b1;
    prev = out3;
    @(negedge clk);
    v3 = 1'b0;
    n_checks++;
    if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL partial_in_ready_busy: got %b want 0", rdy3); end
    for (int i = 0; i < 500; i++) begin
      if (out3 !== prev) begin
        changes++;
        if (changes == 1) snap = out3;
        prev = out3;
      end
      if (val3) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL partial_timeout: out_valid never rose (want within 500 cycles)"); end
    n_checks++;
    if (changes !== 2) begin n_fail++; $display("FAIL partial_groups: got %0d out writes want 2", changes); end
    n_checks++;
    if (snap !== PART_G0) begin n_fail++; $display("FAIL partial_group0: got %h want %h", snap, PART_G0); end
    n_checks++;
    if (out3 !== PART_EXP) begin n_fail++; $display("FAIL partial_out: got %h want %h", out3, PART_EXP); end
    ack3 = 1'b1;
    @(negedge clk);
    ack3 = 1'b0;
    n_checks++;
    if (val3 !== 1'b0 || rdy3 !== 1'b1) begin
      n_fail++; $display("FAIL partial_ack: out_valid=%b in_ready=%b want 0 1", val3, rdy3);
    end
  endtask

  task automatic test_backpressure();
    int cyc, rises;
    @(negedge clk);
    a0 = IDENT; b0 = BMAT; d0 = DHALF; am0 = 1'b0; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    wait_valid0(cyc, rises);
    n_checks++;
    if (cyc < 0) begin n_fail++; $display("FAIL bp_timeout: out_valid never rose (want within 500 cycles)"); end
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin a0 = BMAT; v0 = 1'b1; end
      if (i == 6) v0 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out0 !== BMAT || val0 !== 1'b1 || rdy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: out=%h valid=%b in_ready=%b want %h 1 0", i, out0, val0, rdy0, BMAT);
      end
    end
    ack0 = 1'b1; v0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0; v0 = 1'b0;
    n_checks++;
    if (val0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_fail++; $display("FAIL bp_ack: out_valid=%b in_ready=%b want 0 1", val0, rdy0);
    end
    @(negedge clk);
    n_checks++;
    if (busy0 !== 1'b0 || rdy0 !== 1'b1 || out0 !== BMAT) begin
      n_fail++; $display("FAIL bp_no_capture: busy=%b in_ready=%b out=%h want 0 1 %h", busy0, rdy0, out0, BMAT);
    end
  endtask

  task automatic test_reset_midop();
    bit leaked;
    leaked = 1'b0;
    @(negedge clk);
    a0 = IDENT; b0 = BMAT; d0 = DHALF; am0 = 1'b0; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL midop_busy_before: got %b want 1", busy0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (val0 !== 1'b0 || busy0 !== 1'b0 || rdy0 !== 1'b1) begin
      n_fail++; $display("FAIL midop_flags: valid=%b busy=%b in_ready=%b want 0 0 1", val0, busy0, rdy0);
    end
    n_checks++;
    if (out0 !== 128'd0) begin n_fail++; $display("FAIL midop_out: got %h want 0", out0); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (val0 || busy0) leaked = 1'b1;
    end
    n_checks++;
    if (leaked) begin n_fail++; $display("FAIL midop_no_output: activity after abort, want none"); end
  endtask

  task automatic test_nonsquare();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    an = NS_A; bn = NS_B; dn = {FH, FH}; amn = 1'b0; vn = 1'b1;
    @(negedge clk);
    vn = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (valn) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL ns_timeout: out_valid never rose (want within 500 cycles)"); end
    n_checks++;
    if (outn !== NS_EXP) begin n_fail++; $display("FAIL ns_out: got %h want %h", outn, NS_EXP); end
    ackn = 1'b1;
    @(negedge clk);
    ackn = 1'b0;
    n_checks++;
    if (valn !== 1'b0 || rdyn !== 1'b1) begin
      n_fail++; $display("FAIL ns_ack: out_valid=%b in_ready=%b want 0 1", valn, rdyn);
    end
  endtask

  initial begin
    test_reset();
    test_identity("identity");
    test_accumulate();
    test_partial_group();
    test_backpressure();
    test_nonsquare();
    test_reset_midop();
    test_identity("identity_after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
